// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scan driver: default parameters and
// active-low glyphs (bit 6 = a ... bit 0 = g).
package seg_pkg;

    localparam int DEF_NUM_DIGITS   = 6;
    localparam int DEF_SLOT_CYCLES  = 50000;
    localparam int DEF_BLINK_FRAMES = 64;

    localparam logic [6:0] GLYPH_0     = 7'b0000001;
    localparam logic [6:0] GLYPH_1     = 7'b1001111;
    localparam logic [6:0] GLYPH_2     = 7'b0010010;
    localparam logic [6:0] GLYPH_3     = 7'b0000110;
    localparam logic [6:0] GLYPH_4     = 7'b1001100;
    localparam logic [6:0] GLYPH_5     = 7'b0100100;
    localparam logic [6:0] GLYPH_6     = 7'b0100000;
    localparam logic [6:0] GLYPH_7     = 7'b0001111;
    localparam logic [6:0] GLYPH_8     = 7'b0000000;
    localparam logic [6:0] GLYPH_9     = 7'b0000100;
    localparam logic [6:0] GLYPH_DASH  = 7'b1111110;
    localparam logic [6:0] GLYPH_BLANK = 7'b1111111;

endpackage

// File: rtl/seg_decode.sv
// BCD to active-low seven-segment glyph lookup; non-decimal codes show a dash.
module seg_decode
    import seg_pkg::*;
(
    input  logic [3:0] code,
    output logic [6:0] seg
);

    always_comb begin
        seg = GLYPH_DASH;
        case (code)
            4'd0:    seg = GLYPH_0;
            4'd1:    seg = GLYPH_1;
            4'd2:    seg = GLYPH_2;
            4'd3:    seg = GLYPH_3;
            4'd4:    seg = GLYPH_4;
            4'd5:    seg = GLYPH_5;
            4'd6:    seg = GLYPH_6;
            4'd7:    seg = GLYPH_7;
            4'd8:    seg = GLYPH_8;
            4'd9:    seg = GLYPH_9;
            default: seg = GLYPH_DASH;
        endcase
    end

endmodule

// File: rtl/seg_scan_driver.sv
// Multiplexed seven-segment scan driver with per-frame input snapshot,
// brightness PWM, leading-zero suppression and per-digit blink.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS   = DEF_NUM_DIGITS,
    parameter int SLOT_CYCLES  = DEF_SLOT_CYCLES,
    parameter int BLINK_FRAMES = DEF_BLINK_FRAMES
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   dp,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    input  logic                    lz_en,
    input  logic [3:0]              brightness,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              sseg,
    output logic                    sseg_dp,
    output logic                    frame_tick
);

    localparam int PRESC_W   = $clog2(SLOT_CYCLES);
    localparam int LIM_W     = PRESC_W + 1;
    localparam int SLOT_W    = $clog2(NUM_DIGITS);
    localparam int FRAME_W   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam int SLOT_UNIT = SLOT_CYCLES / 16;

    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(SLOT_CYCLES - 1);
    localparam logic [SLOT_W-1:0]  SLOT_LAST  = SLOT_W'(NUM_DIGITS - 1);
    localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(BLINK_FRAMES - 1);

    logic [PRESC_W-1:0]      presc;
    logic [SLOT_W-1:0]       slot;
    logic                    first_q;
    logic [FRAME_W-1:0]      frame_cnt;
    logic                    blink_on;

    logic [4*NUM_DIGITS-1:0] sh_digits;
    logic [NUM_DIGITS-1:0]   sh_dp;
    logic [NUM_DIGITS-1:0]   sh_blink;
    logic                    sh_lz;
    logic [3:0]              sh_bright;

    logic                    slot_wrap;
    logic                    frame_wrap;
    logic                    snap;
    logic [LIM_W-1:0]        on_limit;
    logic                    an_on;
    logic                    hide;
    logic                    zero_run;
    logic [NUM_DIGITS-1:0]   lz_blank;
    logic [3:0]              sh_dig_arr [NUM_DIGITS];
    logic [3:0]              cur_code;
    logic [6:0]              cur_glyph;

    // first_q holds the counters for one cycle after reset so that the first
    // snapshot lands in the same cycle as prescaler 0 of slot 0.
    assign slot_wrap  = (presc == PRESC_LAST);
    assign frame_wrap = slot_wrap && (slot == SLOT_LAST);
    assign snap       = first_q | frame_wrap;

    assign on_limit = LIM_W'((32'(sh_bright) + 32'd1) * 32'(SLOT_UNIT));
    assign an_on    = (presc != '0) && ({1'b0, presc} < on_limit);
    assign hide     = ~blink_on & sh_blink[slot];
    assign cur_code = sh_dig_arr[slot];

    always_comb begin
        zero_run = 1'b1;
        lz_blank = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            sh_dig_arr[i] = sh_digits[4*i +: 4];
            zero_run      = zero_run & (sh_digits[4*i +: 4] == 4'd0);
            lz_blank[i]   = sh_lz & zero_run & (i != 0);
        end
    end

    seg_decode u_decode (
        .code (cur_code),
        .seg  (cur_glyph)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            presc      <= '0;
            slot       <= '0;
            first_q    <= 1'b1;
            frame_tick <= 1'b0;
        end else begin
            first_q    <= 1'b0;
            frame_tick <= snap;
            if (!first_q) begin
                if (slot_wrap) begin
                    presc <= '0;
                    slot  <= (slot == SLOT_LAST) ? '0 : slot + 1'b1;
                end else begin
                    presc <= presc + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sh_digits <= '0;
            sh_dp     <= '0;
            sh_blink  <= '0;
            sh_lz     <= 1'b0;
            sh_bright <= '0;
            frame_cnt <= '0;
            blink_on  <= 1'b1;
        end else if (snap) begin
            sh_digits <= digits;
            sh_dp     <= dp;
            sh_blink  <= blink_mask;
            sh_lz     <= lz_en;
            sh_bright <= brightness;
            if (frame_wrap) begin
                if (frame_cnt == FRAME_LAST) begin
                    frame_cnt <= '0;
                    blink_on  <= ~blink_on;
                end else begin
                    frame_cnt <= frame_cnt + 1'b1;
                end
            end
        end
    end

    // Outputs are registered from the current prescaler/slot, so they trail
    // the counter state by one cycle.
    always_ff @(posedge clk) begin
        if (rst || first_q) begin
            an      <= '1;
            sseg    <= GLYPH_BLANK;
            sseg_dp <= 1'b1;
        end else begin
            an <= an_on ? ~(NUM_DIGITS'(1) << slot) : '1;
            if (hide) begin
                sseg    <= GLYPH_BLANK;
                sseg_dp <= 1'b1;
            end else begin
                sseg    <= lz_blank[slot] ? GLYPH_BLANK : cur_glyph;
                sseg_dp <= ~sh_dp[slot];
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench for seg_scan_driver: per-cycle expected outputs are
// derived from the frame snapshot the bench recorded and queued for the monitor.
module tb_seg_scan_driver;

    localparam int ND    = 6;
    localparam int SC    = 16;
    localparam int BF    = 2;
    localparam int FRAME = ND * SC;
    localparam int EW    = 15;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [23:0] digits;
    logic [5:0]  dp;
    logic [5:0]  blink_mask;
    logic        lz_en;
    logic [3:0]  brightness;
    logic [5:0]  an;
    logic [6:0]  sseg;
    logic        sseg_dp;
    logic        frame_tick;

    always #5 clk = ~clk;

    seg_scan_driver #(
        .NUM_DIGITS   (ND),
        .SLOT_CYCLES  (SC),
        .BLINK_FRAMES (BF)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .digits     (digits),
        .dp         (dp),
        .blink_mask (blink_mask),
        .lz_en      (lz_en),
        .brightness (brightness),
        .an         (an),
        .sseg       (sseg),
        .sseg_dp    (sseg_dp),
        .frame_tick (frame_tick)
    );

    int total = 0;
    int bad   = 0;
    int n     = -1;
    logic [EW-1:0] exp_q[$];

    logic [23:0] snap_dig [256];
    logic [5:0]  snap_dp  [256];
    logic [5:0]  snap_bm  [256];
    logic        snap_lz  [256];
    logic [3:0]  snap_br  [256];

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s n=%0d got=%b want=%b", tag, n, got, want);
        end
    endtask

    // Active-low glyphs written as the complement of the lit segments abcdefg.
    function automatic logic [6:0] glyph(input logic [3:0] c);
        case (c)
            4'd0:    return ~7'b1111110;
            4'd1:    return ~7'b0110000;
            4'd2:    return ~7'b1101101;
            4'd3:    return ~7'b1111001;
            4'd4:    return ~7'b0110011;
            4'd5:    return ~7'b1011011;
            4'd6:    return ~7'b1011111;
            4'd7:    return ~7'b1110000;
            4'd8:    return ~7'b1111111;
            4'd9:    return ~7'b1111011;
            default: return ~7'b0000001;
        endcase
    endfunction

    // Cycle k counts from the frame_tick cycle after reset; outputs in cycle k
    // reflect the scan position of cycle k-1.
    function automatic logic [EW-1:0] expect_at(input int k);
        logic       tick;
        logic [5:0] a;
        logic [6:0] sg;
        logic       d;
        logic [3:0] c;
        int m, f, p, s;
        tick = (k % FRAME == 0);
        a    = '1;
        sg   = 7'h7F;
        d    = 1'b1;
        if (k >= 1) begin
            m = k - 1;
            f = m / FRAME;
            p = m % SC;
            s = (m / SC) % ND;
            if (p != 0 && p < (int'(snap_br[f]) + 1) * (SC / 16))
                a = ~(6'd1 << s);
            c = 4'(snap_dig[f] >> (4 * s));
            if (!(((f / BF) % 2 == 1) && snap_bm[f][s])) begin
                if (snap_lz[f] && s != 0 && (snap_dig[f] >> (4 * s)) == 24'd0)
                    sg = 7'h7F;
                else
                    sg = glyph(c);
                d = ~snap_dp[f][s];
            end
        end
        return {tick, a, sg, d};
    endfunction

    task automatic record(input int f);
        snap_dig[f] = digits;
        snap_dp[f]  = dp;
        snap_bm[f]  = blink_mask;
        snap_lz[f]  = lz_en;
        snap_br[f]  = brightness;
    endtask

    task automatic step(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            if ((n + 1) % FRAME == 0) record((n + 1) / FRAME);
            @(posedge clk);
            #1;
            n++;
            exp_q.push_back(expect_at(n));
        end
    endtask

    task automatic step_to(input int pos);
        step(((pos - (n % FRAME)) + FRAME) % FRAME);
    endtask

    task automatic hold_reset(input int cycles);
        rst = 1'b1;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            exp_q.push_back({1'b0, 6'h3F, 7'h7F, 1'b1});
        end
        rst = 1'b0;
        n   = -1;
    endtask

    always @(negedge clk) begin
        logic [EW-1:0] e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check_eq("frame_tick", {7'd0, frame_tick}, {7'd0, e[14]});
            check_eq("an", {2'd0, an}, {2'd0, e[13:8]});
            check_eq("sseg", {1'b0, sseg}, {1'b0, e[7:1]});
            check_eq("sseg_dp", {7'd0, sseg_dp}, {7'd0, e[0]});
        end
    end

    initial begin
        digits     = 24'h123456;
        dp         = '0;
        blink_mask = '0;
        lz_en      = 1'b0;
        brightness = 4'd15;

        hold_reset(3);
        step(2 * FRAME);

        brightness = 4'd3;
        step(2 * FRAME);
        brightness = 4'd0;
        step(2 * FRAME);

        brightness = 4'd15;
        lz_en      = 1'b1;
        digits     = 24'h000705;
        dp         = 6'b010001;
        step(2 * FRAME);
        digits = 24'h000000;
        step(2 * FRAME);

        lz_en      = 1'b0;
        dp         = 6'b000011;
        digits     = 24'h987654;
        blink_mask = 6'b000011;
        step(8 * FRAME);

        // Mid-frame change inside slot 3 must wait for the next snapshot.
        blink_mask = '0;
        step_to(3 * SC + 5);
        digits = 24'h00C000;
        step(2 * FRAME);

        for (int r = 0; r < 8; r++) begin
            digits     = 24'($urandom);
            dp         = 6'($urandom);
            blink_mask = 6'($urandom);
            lz_en      = 1'($urandom_range(0, 1));
            brightness = 4'($urandom_range(0, 15));
            step(int'($urandom_range(30, 200)));
        end

        digits     = 24'h123456;
        blink_mask = 6'b100001;
        step_to(4 * SC + 6);
        hold_reset(3);
        step(5 * FRAME);

        @(negedge clk);
        #1;
        check_eq("q_drain", 8'(exp_q.size()), 8'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seg_scan_driver.md
SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 6, number of multiplexed digits (2..8).
REQ-002 SHALL have parameter SLOT_CYCLES, default 50000, clk cycles per digit slot; a multiple of 16 and at least 16.
REQ-003 SHALL have parameter BLINK_FRAMES, default 64, frames per blink half-period (at least 1).
REQ-004 SHALL have port clk, input, 1, system clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have port digits, input, 4*NUM_DIGITS, BCD value per digit; digit i in bits [4i+3:4i]; digit 0 is rightmost.
REQ-007 SHALL have port dp, input, NUM_DIGITS, decimal point request per digit.
REQ-008 SHALL have port blink_mask, input, NUM_DIGITS, digits to flash for time-setting mode.
REQ-009 SHALL have port lz_en, input, 1, leading-zero suppression enable.
REQ-010 SHALL have port brightness, input, 4, duty level 0..15.
REQ-011 SHALL have port an, output, NUM_DIGITS, active-low anode enables.
REQ-012 SHALL have port sseg, output, 7, active-low segments; bit 6 = a through bit 0 = g.
REQ-013 SHALL have port sseg_dp, output, 1, active-low decimal point.
REQ-014 SHALL have port frame_tick, output, 1, one-cycle pulse at the start of each frame.

Function
REQ-015 SHALL count a prescaler 0..SLOT_CYCLES-1 and wrap to 0; the wrap advances the slot index 0..NUM_DIGITS-1, which wraps to 0.
REQ-016 SHALL use clk-enable ticks only; no derived clocks.
REQ-017 SHALL snapshot digits, dp, blink_mask, lz_en and brightness into shadow registers when the slot index becomes 0, so one frame shows one consistent value.
REQ-018 SHALL pulse frame_tick for one cycle in the same cycle as the snapshot.
REQ-019 SHALL drive exactly one an bit low in slot i, and only while prescaler < (brightness+1)*SLOT_CYCLES/16; otherwise all an bits are high.
REQ-020 SHALL force all an bits high on prescaler == 0 of every slot, as an anti-ghosting gap, regardless of brightness.
REQ-021 SHALL register an, sseg and sseg_dp, which update one clk cycle after the prescaler value that selects them.
REQ-022 SHALL decode BCD 0..9 to standard glyphs; codes 10..15 SHALL show segment g only (a dash).
REQ-023 With lz_en=1, SHALL blank digit i (sseg all 1s) when it and every higher digit are 0; digit 0 is never blanked.
REQ-024 SHALL toggle a blink phase every BLINK_FRAMES frames; in the off phase, digits with shadow blink_mask set SHALL drive sseg and sseg_dp all 1s while an still scans.
REQ-025 SHALL drive sseg_dp = ~shadow dp[slot], subject to blink; leading-zero blanking does not suppress dp.
REQ-026 SHALL ignore input changes mid-frame; they appear at the next snapshot only.

Reset
REQ-027 On rst=1, SHALL set an all 1s, sseg 7'b1111111, sseg_dp 1, frame_tick 0, prescaler 0, slot 0, frame counter 0, blink phase on (visible), and shadow registers 0.
REQ-028 SHALL make the first snapshot and frame_tick in the first cycle after rst deasserts.
REQ-029 When rst asserts mid-slot, SHALL blank outputs in the next cycle with no partial-slot completion.

Structure
REQ-030 SHALL place segment glyph constants (0..9, dash, blank) and the default parameter values in shared package seg_pkg.
REQ-031 SHALL implement glyph lookup in combinational sub-module seg_decode (4-bit in, 7-bit active-low out), instantiated once on the muxed digit.
REQ-032 SHALL size counters from parameters using clog2, with no fixed widths.

Verification (NUM_DIGITS=6, SLOT_CYCLES=16, BLINK_FRAMES=2)
REQ-033 Reset, then digits=0x123456, brightness=15, masks 0 -> an cycles 111110..011111, each low 15 of 16 cycles; glyphs 6,5,4,3,2,1; frame_tick every 96 cycles.
REQ-034 brightness=3 -> each an low exactly on prescaler 1..3 (3 cycles per slot); brightness=0 -> an never low, because the gap removes the only on-cycle.
REQ-035 lz_en=1, digits=0x000705 -> digits 5,4,3 blank, digit 2 shows 7, digit 1 shows 0, digit 0 shows 5; digits=0 -> only digit 0 shows 0.
REQ-036 blink_mask=6'b000011 -> digits 0,1 all-off in frames 2-3, 6-7, ...; other digits unaffected; an pattern unchanged.
REQ-037 Change digits mid-frame (slot 3) -> no change until the next frame_tick; code 4'hC displays dash (sseg 7'b1111110).
REQ-038 Assert rst during slot 4 -> an all 1s next cycle; after release, the scan restarts at slot 0 with frame_tick.
